// File: rtl/dac_pkg.sv
// Shared types and constants for the LTC2624 SPI transmitter.
package dac_pkg;

    localparam int unsigned FRAME_W          = 32;
    localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0]  ADDR_ALL         = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_e;

    // 32-bit LTC2624 frame: 8 don't-care bits, command, address, 12-bit code, 4 pad bits.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                       input logic [3:0]  addr,
                                                       input logic [11:0] code);
        return {8'h00, cmd, addr, code, 4'h0};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: while enabled, emits a one-clock rise or fall strobe
// every HALF clocks, starting with a rise after the first low half-period.
module spi_clk_div #(
    parameter int unsigned HALF = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;

    assign wrap   = en_i && (cnt_q == CW'(HALF - 1));
    assign rise_o = wrap & ~phase_q;
    assign fall_o = wrap & phase_q;

    // Next-state: count within a half-period, toggle phase on wrap, clear when disabled.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/dac_spi_master.sv
// LTC2624 SPI master: serialises one 32-bit frame MSB first and captures the
// word echoed on DAC_OUT. All outputs come straight from flops.
module dac_spi_master
    import dac_pkg::*;
#(
    parameter int unsigned HALF     = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic                CLK50MHZ,
    input  logic                RST,
    input  logic [11:0]         data,
    input  logic [3:0]          address,
    input  logic [3:0]          command,
    input  logic                dactrig,
    output logic                dacdone,
    output logic [FRAME_W-1:0]  dac_datareceived,
    output logic                busy,
    output logic                SPI_SCK,
    output logic                SPI_MOSI,
    output logic                DAC_CS,
    output logic                DAC_CLR,
    input  logic                DAC_OUT
);

    localparam int unsigned TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [FRAME_W-1:0] drx_q, drx_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_q, cs_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               sck_rise, sck_fall, div_en;
    logic [FRAME_W-1:0] frame_in;

    assign div_en   = (state_q == SHIFT);
    assign frame_in = build_frame(command, address, data);

    spi_clk_div #(
        .HALF (HALF)
    ) u_clk_div (
        .clk_i  (CLK50MHZ),
        .rst_ni (RST),
        .en_i   (div_en),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        drx_d     = drx_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        clr_d     = 1'b1;  // clear released on the first clock after reset
        done_d    = 1'b0;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                if (dactrig) begin
                    tx_d      = frame_in;
                    mosi_d    = frame_in[FRAME_W-1];
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tmr_q == TW'(CS_SETUP - 1)) begin
                    tmr_d   = '0;
                    state_d = SHIFT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[FRAME_W-2:0], DAC_OUT};
                end
                if (sck_fall) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == 5'd31) begin
                        tmr_d   = '0;
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = {tx_q[FRAME_W-2:0], 1'b0};
                        mosi_d    = tx_q[FRAME_W-2];
                    end
                end
            end
            HOLD: begin
                if (tmr_q == TW'(CS_HOLD - 1)) begin
                    tmr_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    drx_d   = rx_q;
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the bus idle immediately.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            drx_q     <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            drx_q     <= drx_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign dacdone          = done_q;
    assign dac_datareceived = drx_q;
    assign busy             = busy_q;
    assign SPI_SCK          = sck_q;
    assign SPI_MOSI         = mosi_q;
    assign DAC_CS           = cs_q;
    assign DAC_CLR          = clr_q;

endmodule

// File: tb/tb_dac_spi_master.sv
// Bench for dac_spi_master: LTC2624 SDO echo model plus a frame scoreboard.
module tb_dac_spi_master;

    localparam int unsigned HALF     = 4;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;
    // dacdone rises this many clocks after the accepting edge; the frame spans
    // two more clocks (the IDLE accept cycle and the DONE cycle).
    localparam int LAT   = CS_SETUP + 64 * HALF + CS_HOLD;
    localparam int F_LAT = 1 + 64 * 1 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    // Default-parameter DUT signals.
    logic        trig = 1'b0;
    logic [11:0] data = '0;
    logic [3:0]  addr = '0, cmd = '0;
    logic        dacdone, busy, sck, mosi, cs, clr, dout;
    logic [31:0] drx;

    // Fast-parameter DUT signals.
    logic        f_trig = 1'b0;
    logic [11:0] f_data = '0;
    logic [3:0]  f_addr = 4'hF, f_cmd = 4'h3;
    logic        f_dacdone, f_busy, f_sck, f_mosi, f_cs, f_clr, f_dout;
    logic [31:0] f_drx;

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] exp_q[$];
    logic [31:0] echo_q[$];
    logic [31:0] sb_exp, sb_echo;

    function automatic logic [31:0] exp_frame(input logic [3:0] c, input logic [3:0] a,
                                              input logic [11:0] d);
        return {8'h00, c, a, d, 4'h0};
    endfunction

    dac_spi_master dut (
        .CLK50MHZ         (clk),
        .RST              (rst_n),
        .data             (data),
        .address          (addr),
        .command          (cmd),
        .dactrig          (trig),
        .dacdone          (dacdone),
        .dac_datareceived (drx),
        .busy             (busy),
        .SPI_SCK          (sck),
        .SPI_MOSI         (mosi),
        .DAC_CS           (cs),
        .DAC_CLR          (clr),
        .DAC_OUT          (dout)
    );

    dac_spi_master #(
        .HALF     (1),
        .CS_SETUP (1),
        .CS_HOLD  (1)
    ) dut_f (
        .CLK50MHZ         (clk),
        .RST              (rst_n),
        .data             (f_data),
        .address          (f_addr),
        .command          (f_cmd),
        .dactrig          (f_trig),
        .dacdone          (f_dacdone),
        .dac_datareceived (f_drx),
        .busy             (f_busy),
        .SPI_SCK          (f_sck),
        .SPI_MOSI         (f_mosi),
        .DAC_CS           (f_cs),
        .DAC_CLR          (f_clr),
        .DAC_OUT          (f_dout)
    );

    // LTC2624 SDO model: shifts out the previous frame on SCK falls, captures MOSI on rises.
    logic [31:0] m_in = '0, m_out = '0, m_prev = '0;
    int          m_rises = 0;
    assign dout = m_out[31];
    always @(negedge cs) begin
        m_out = m_prev;
        echo_q.push_back(m_prev);
        m_rises = 0;
    end
    always @(posedge sck) begin
        m_in = {m_in[30:0], mosi};
        m_rises++;
    end
    always @(negedge sck) m_out <= {m_out[30:0], 1'b0};
    always @(posedge cs) m_prev = m_in;

    logic [31:0] f_in = '0, f_out = '0, f_prev = '0;
    int          f_rises = 0;
    assign f_dout = f_out[31];
    always @(negedge f_cs) begin
        f_out = f_prev;
        f_rises = 0;
    end
    always @(posedge f_sck) begin
        f_in = {f_in[30:0], f_mosi};
        f_rises++;
    end
    always @(negedge f_sck) f_out <= {f_out[30:0], 1'b0};
    always @(posedge f_cs) f_prev = f_in;

    // Scoreboard: at every dacdone, pop the expected MOSI word and expected echo.
    always @(negedge clk) begin
        if (rst_n && dacdone === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_done: dacdone with no frame expected");
            end else begin
                sb_exp = exp_q.pop_front();
                if (m_in !== sb_exp) begin
                    fails++;
                    $display("FAIL sb_mosi_word: got %h expected %h", m_in, sb_exp);
                end
            end
            tests_run++;
            if (m_rises !== 32) begin
                fails++;
                $display("FAIL sb_sck_rises: got %0d expected 32", m_rises);
            end
            tests_run++;
            if (echo_q.size() == 0) begin
                fails++;
                $display("FAIL sb_echo_missing: no echo recorded for frame");
            end else begin
                sb_echo = echo_q.pop_front();
                if (drx !== sb_echo) begin
                    fails++;
                    $display("FAIL sb_echo: got %h expected %h", drx, sb_echo);
                end
            end
        end
    end

    task automatic test_reset;
        int pulses = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cs !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || f_cs !== 1'b1) begin
            fails++;
            $display("FAIL reset_bus: cs=%b sck=%b mosi=%b f_cs=%b expected 1 0 0 1",
                     cs, sck, mosi, f_cs);
        end
        tests_run++;
        if (clr !== 1'b0 || dacdone !== 1'b0 || busy !== 1'b0 || drx !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: clr=%b done=%b busy=%b drx=%h expected 0 0 0 0",
                     clr, dacdone, busy, drx);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (clr !== 1'b0) begin
            fails++;
            $display("FAIL clr_before_clock: got %b expected 0", clr);
        end
        @(negedge clk);
        tests_run++;
        if (clr !== 1'b1) begin
            fails++;
            $display("FAIL clr_after_clock: got %b expected 1", clr);
        end
        repeat (20) begin
            @(negedge clk);
            if (dacdone !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses != 0 || cs !== 1'b1) begin
            fails++;
            $display("FAIL idle_quiet: pulses=%0d cs=%b expected 0 and 1", pulses, cs);
        end
    endtask

    task automatic test_single_frame;
        int n = 0;
        @(negedge clk);
        cmd  = 4'b0011;
        addr = 4'b1111;
        data = 12'hABC;
        trig = 1'b1;
        exp_q.push_back(32'h003FABC0);
        @(posedge clk);
        @(negedge clk);
        trig = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || cs !== 1'b0) begin
            fails++;
            $display("FAIL accept: busy=%b cs=%b expected 1 0", busy, cs);
        end
        while (dacdone !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != LAT) begin
            fails++;
            $display("FAIL frame_latency: got %0d clocks expected %0d", n, LAT);
        end
        @(negedge clk);
        tests_run++;
        if (dacdone !== 1'b0 || busy !== 1'b0 || cs !== 1'b1) begin
            fails++;
            $display("FAIL done_single_pulse: done=%b busy=%b cs=%b expected 0 0 1",
                     dacdone, busy, cs);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int lows = 0;
        @(negedge clk);
        data = 12'h123;
        trig = 1'b1;
        exp_q.push_back(32'h003F1230);
        @(negedge clk);
        trig = 1'b0;
        while (dacdone !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        // Request the next frame during DONE; only the IDLE cycle should show busy low.
        data = 12'h456;
        trig = 1'b1;
        exp_q.push_back(32'h003F4560);
        n = 0;
        @(negedge clk);
        if (busy === 1'b0) lows++;
        @(negedge clk);
        trig = 1'b0;
        while (dacdone !== 1'b1 && n < 1000) begin
            if (busy === 1'b0) lows++;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (lows != 1) begin
            fails++;
            $display("FAIL busy_gap: busy low %0d clocks between frames expected 1", lows);
        end
        tests_run++;
        if (drx !== 32'h003F1230) begin
            fails++;
            $display("FAIL echo_second: got %h expected %h", drx, 32'h003F1230);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (drx !== 32'h003F1230) begin
            fails++;
            $display("FAIL echo_hold: got %h expected %h", drx, 32'h003F1230);
        end
    endtask

    task automatic test_held_trig;
        int  starts = 0, dones = 0, run = 0, n = 0, bad_gaps = 0;
        logic prev_cs = 1'b1;
        @(negedge clk);
        data = 12'h111;
        trig = 1'b1;
        exp_q.push_back(exp_frame(cmd, addr, 12'h111));
        while (dones < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (dacdone === 1'b1) dones++;
            if (prev_cs === 1'b1 && cs === 1'b0) begin
                starts++;
                if (starts >= 2 && run < 2) bad_gaps++;
                // Change inputs mid-frame; the next acceptance must pick them up.
                if (starts == 1) begin
                    data = 12'h222;
                    exp_q.push_back(exp_frame(cmd, addr, 12'h222));
                end else if (starts == 2) begin
                    data = 12'h333;
                    exp_q.push_back(exp_frame(cmd, addr, 12'h333));
                end else if (starts == 3) begin
                    trig = 1'b0;
                end
            end
            run     = (cs === 1'b1) ? run + 1 : 0;
            prev_cs = cs;
        end
        tests_run++;
        if (dones != 3 || starts != 3) begin
            fails++;
            $display("FAIL held_frames: dones=%0d starts=%0d expected 3 3", dones, starts);
        end
        tests_run++;
        if (bad_gaps != 0) begin
            fails++;
            $display("FAIL cs_gap: %0d gaps shorter than 2 clocks expected 0", bad_gaps);
        end
        repeat (300) @(negedge clk);
        tests_run++;
        if (cs !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL no_queued_frame: cs=%b busy=%b expected 1 0", cs, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int   rises = 0, n = 0, pulses = 0;
        logic prev_sck = 1'b0;
        @(negedge clk);
        data = 12'h789;
        trig = 1'b1;
        exp_q.push_back(exp_frame(cmd, addr, 12'h789));
        @(negedge clk);
        trig = 1'b0;
        while (rises < 17 && n < 1000) begin
            @(negedge clk);
            n++;
            if (prev_sck === 1'b0 && sck === 1'b1) rises++;
            prev_sck = sck;
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (rises != 17 || cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rises=%0d cs=%b sck=%b busy=%b expected 17 1 0 0",
                     rises, cs, sck, busy);
        end
        exp_q.delete();
        echo_q.delete();
        repeat (3) begin
            @(negedge clk);
            if (dacdone !== 1'b0) pulses++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (dacdone !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses != 0 || drx !== 32'h0) begin
            fails++;
            $display("FAIL abort_no_done: pulses=%0d drx=%h expected 0 0", pulses, drx);
        end
        data = 12'h5A5;
        trig = 1'b1;
        exp_q.push_back(32'h003F5A50);
        @(negedge clk);
        trig = 1'b0;
        n = 0;
        while (dacdone !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL frame_after_reset: no dacdone within %0d clocks", n);
        end
        @(negedge clk);
    endtask

    task automatic test_fast_params;
        int          n = 0;
        logic [31:0] w1, w2;
        w1 = exp_frame(f_cmd, f_addr, 12'h321);
        w2 = exp_frame(f_cmd, f_addr, 12'h654);
        @(negedge clk);
        f_data = 12'h321;
        f_trig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_trig = 1'b0;
        while (f_dacdone !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != F_LAT) begin
            fails++;
            $display("FAIL fast_latency: got %0d clocks expected %0d", n, F_LAT);
        end
        tests_run++;
        if (f_in !== w1 || f_rises != 32) begin
            fails++;
            $display("FAIL fast_frame1: word=%h rises=%0d expected %h 32", f_in, f_rises, w1);
        end
        f_data = 12'h654;
        f_trig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        f_trig = 1'b0;
        n = 0;
        while (f_dacdone !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (f_in !== w2 || f_rises != 32) begin
            fails++;
            $display("FAIL fast_frame2: word=%h rises=%0d expected %h 32", f_in, f_rises, w2);
        end
        tests_run++;
        if (f_drx !== w1) begin
            fails++;
            $display("FAIL fast_echo: got %h expected %h", f_drx, w1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_held_trig();
        test_reset_mid_frame();
        test_fast_params();
        repeat (5) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected frames never completed", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
